ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
Synthesizable configuration-chain programmer. It drives ccff_head and the chain shift enable, and observes ccff_tail at the far end of the fabric configuration chain.
- Before programming, it flushes the chain and measures its length by timing a single marker bit from head to tail.
- It then serializes a word-streamed bitstream into the chain and raises config_done.
- It sits between an on-chip bitstream source (memory/DMA, valid/ready) and the fpga_top configuration port. It replaces bench-side ccff_head driving on silicon and emulation targets.

Parameters:
- BS_LGT, 8387, number of configuration flops in the chain; also the bitstream length in bits.
- WORD_W, 32, bitstream word width.
- CNT_W, 16, width of the bit and length counters; must satisfy 2^CNT_W > 2*BS_LGT.

Ports:
- prog_clk  in  1  programming clock; all logic on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins flush, probe and load.
- word_data  in  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word_data this cycle.
- ccff_head  out  1  serial data into the chain (registered).
- shift_en  out  1  chain shifts on this prog_clk edge when high (registered; drives the clock gate).
- ccff_tail  in  1  chain output, sampled every cycle.
- busy  out  1  sequence in progress.
- config_done  out  1  chain fully loaded and length verified.
- err_code  out  2  0 = none, 1 = stuck-at-1 tail, 2 = length mismatch, 3 = probe timeout.
- chain_len  out  CNT_W  measured chain length.

Behaviour:
- Interface timing: one clock (prog_clk); reset pReset is synchronous and active-high.
- Reset values: ccff_head=0, shift_en=0, word_ready=0, busy=0, config_done=0, err_code=0, chain_len=0, state=IDLE. A pReset asserted in any state returns to these values on the next edge; any partial chain contents are abandoned.
- State machine: IDLE → FLUSH → PROBE → LOAD → DONE; FAIL is reachable from FLUSH and PROBE.
- IDLE:
  - start=1 → FLUSH; busy=1, config_done=0, err_code=0, bit counter=0.
- FLUSH:
  - shift_en=1, ccff_head=0 for exactly BS_LGT cycles.
  - On the cycle after the last flush shift, ccff_tail must be 0. If it is 1 → FAIL, err_code=1.
  - Otherwise → PROBE.
- PROBE:
  - The first cycle injects the marker: ccff_head=1, shift_en=1, length counter=1.
  - Every following cycle: ccff_head=0, shift_en=1, counter increments.
  - ccff_tail is sampled each cycle after a shift. On the first sample of 1, chain_len is latched with the counter value, which is the count of shifts including the injection. For an N-flop chain, chain_len=N.
  - chain_len==BS_LGT → LOAD. chain_len≠BS_LGT → FAIL, err_code=2.
  - Counter reaching 2*BS_LGT with no tail=1 → FAIL, err_code=3, chain_len=2*BS_LGT.
- LOAD:
  - Bit counter cleared on entry.
  - word_ready=1 only when the internal shift register is empty. Handshake is word_valid && word_ready.
  - An accepted word is shifted LSB-first, one bit per cycle with shift_en=1, starting the cycle after acceptance.
  - If the register is empty and word_valid=0: shift_en=0, ccff_head held, no shift (stall). This must not alter chain contents.
  - After exactly BS_LGT shifted bits: any remaining bits of the final word are discarded, shift_en=0 on the next cycle, → DONE.
  - The probe marker (and any other non-bitstream bits) exits the tail during LOAD; it is ignored.
- DONE:
  - config_done=1, busy=0, shift_en=0, word_ready=0.
  - start → FLUSH (reconfiguration); config_done drops on the same edge.
- FAIL:
  - busy=0, shift_en=0, err_code held.
  - start → FLUSH, clearing err_code.
- start while busy=1 is ignored.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Total cycles start→config_done with no stalls: BS_LGT (flush) + 1 (tail check) + BS_LGT (probe, chain matching) + BS_LGT + ceil(BS_LGT/WORD_W) (load handshakes) + small fixed overhead (≤4).

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enum (IDLE, FLUSH, PROBE, LOAD, DONE, FAIL);
  - the err_code localparams (ERR_NONE, ERR_STUCK1, ERR_LEN, ERR_TIMEOUT).
- Sub-module ccff_word_serializer: WORD_W shift register with valid/ready input, a bit-remaining count, and a stall output. The top FSM owns FLUSH, PROBE and the length check.

Test Plan:
- BS_LGT=16, WORD_W=8, 16-flop behavioural chain, words 0xC3 then 0xA5 → chain_len=16, err_code=0, config_done=1. Chain holds 0xA5C3, first-shifted bit at the tail-side flop.
- 15-flop chain with BS_LGT=16 → FAIL, err_code=2, chain_len=15, config_done=0, shift_en=0.
- ccff_tail tied 1 → FAIL with err_code=1 on the cycle after the 16th flush shift.
- ccff_tail tied 0 → FAIL with err_code=3 after 32 probe shifts, chain_len=32.
- word_valid deasserted 5 cycles between words → shift_en=0 for exactly those stall cycles; final chain contents identical to the no-stall run.
- pReset pulsed mid-LOAD → all outputs at reset values on the next edge. A following start completes normally with chain_len=16.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types for the configuration-chain loader: FSM states and error codes.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FLUSH,
    PROBE,
    LOAD,
    DONE,
    FAIL
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_STUCK1  = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream-source and fabric-chain signals of the loader; master is the loader side.
interface ccff_chain_loader_if #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) ();

  logic              start;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              shift_en;
  logic              ccff_tail;
  logic              busy;
  logic              config_done;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  chain_len;

  modport master (
    input  start, word_data, word_valid, ccff_tail,
    output word_ready, ccff_head, shift_en, busy, config_done, err_code, chain_len
  );

  modport slave (
    output start, word_data, word_valid, ccff_tail,
    input  word_ready, ccff_head, shift_en, busy, config_done, err_code, chain_len
  );

endinterface

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer: accepts a word only when empty and hands out bits LSB first.
module ccff_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              enable_i,
  input  logic [WORD_W-1:0] word_data_i,
  input  logic              word_valid_i,
  output logic              word_ready_o,
  output logic              bit_o,
  output logic              stall_o
);

  localparam int REM_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] sr_q, sr_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic              accept;

  always_comb begin
    word_ready_o = enable_i && (rem_q == '0);
    accept       = word_ready_o && word_valid_i;
    stall_o      = word_ready_o && !word_valid_i;
    // bit 0 of a freshly accepted word goes straight out; the rest wait in sr_q
    bit_o        = accept ? word_data_i[0] : sr_q[0];
    sr_d         = sr_q;
    rem_d        = rem_q;
    if (!enable_i) begin
      rem_d = '0;
    end else if (accept) begin
      sr_d  = word_data_i >> 1;
      rem_d = REM_W'(WORD_W - 1);
    end else if (rem_q != '0) begin
      sr_d  = sr_q >> 1;
      rem_d = rem_q - REM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      sr_q  <= '0;
      rem_q <= '0;
    end else begin
      sr_q  <= sr_d;
      rem_q <= rem_d;
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer: flush, marker-based length probe, then bitstream load.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int BS_LGT = 8387,
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input logic                 prog_clk,
  input logic                 pReset,
  ccff_chain_loader_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_BS  = CNT_W'(BS_LGT);
  localparam logic [CNT_W-1:0] CNT_2BS = CNT_W'(2 * BS_LGT);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] probe_len;
  logic [1:0]       err_q;
  logic             head_q, shift_en_q, busy_q, done_q;
  logic             ser_en, ser_ready, ser_bit, ser_stall;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // tail reflects the shifts completed before this edge, one fewer than issued
  assign probe_len = cnt_q - CNT_W'(1);
  assign ser_en    = (state_q == LOAD) && (cnt_q < CNT_BS);

  ccff_word_serializer #(.WORD_W(WORD_W)) u_ser (
    .clk          (prog_clk),
    .srst         (pReset),
    .enable_i     (ser_en),
    .word_data_i  (bus.word_data),
    .word_valid_i (bus.word_valid),
    .word_ready_o (ser_ready),
    .bit_o        (ser_bit),
    .stall_o      (ser_stall)
  );

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      err_q      <= ERR_NONE;
      head_q     <= 1'b0;
      shift_en_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE, FAIL: begin
          if (bus.start) begin
            state_q    <= FLUSH;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= ERR_NONE;
            cnt_q      <= '0;
            head_q     <= 1'b0;
            shift_en_q <= 1'b1;
          end
        end
        FLUSH: begin
          if (cnt_q == CNT_BS) begin
            if (bus.ccff_tail) begin
              state_q <= FAIL;
              err_q   <= ERR_STUCK1;
              busy_q  <= 1'b0;
            end else begin
              state_q    <= PROBE;
              head_q     <= 1'b1;
              shift_en_q <= 1'b1;
              cnt_q      <= CNT_W'(1);
            end
          end else begin
            cnt_q <= sat_inc(cnt_q);
            if (cnt_q == CNT_BS - CNT_W'(1)) shift_en_q <= 1'b0;
          end
        end
        PROBE: begin
          head_q <= 1'b0;
          if (bus.ccff_tail) begin
            len_q      <= probe_len;
            shift_en_q <= 1'b0;
            if (probe_len == CNT_BS) begin
              state_q <= LOAD;
              cnt_q   <= '0;
            end else begin
              state_q <= FAIL;
              err_q   <= ERR_LEN;
              busy_q  <= 1'b0;
            end
          end else if (cnt_q >= CNT_2BS) begin
            state_q    <= FAIL;
            err_q      <= ERR_TIMEOUT;
            len_q      <= CNT_2BS;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        LOAD: begin
          // the last issued bit shifts on this edge; leftover word bits are dropped
          if (cnt_q == CNT_BS) begin
            state_q    <= DONE;
            shift_en_q <= 1'b0;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else if (ser_stall) begin
            shift_en_q <= 1'b0;
          end else begin
            head_q     <= ser_bit;
            shift_en_q <= 1'b1;
            cnt_q      <= sat_inc(cnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.word_ready  = ser_ready;
  assign bus.ccff_head   = head_q;
  assign bus.shift_en    = shift_en_q;
  assign bus.busy        = busy_q;
  assign bus.config_done = done_q;
  assign bus.err_code    = err_q;
  assign bus.chain_len   = len_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: behavioural chain of selectable length or tied tail, two-word bitstream.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  localparam int BS_LGT  = 16;
  localparam int WORD_W  = 8;
  localparam int CNT_W   = 16;
  localparam int CYC_MAX = 300;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader_if #(.WORD_W(WORD_W), .CNT_W(CNT_W)) bus ();

  ccff_chain_loader #(.BS_LGT(BS_LGT), .WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (bus)
  );

  logic [31:0] chain = 32'hDEAD_BEEF;
  int          chain_n   = 16;
  int          tail_mode = 0;   // 0 = chain, 1 = tied 1, 2 = tied 0
  int          n_checks  = 0;
  int          n_fail    = 0;

  // flop 0 is the tail-side flop; head enters at flop chain_n-1
  always @(posedge prog_clk) begin
    if (bus.shift_en) begin
      logic [31:0] nxt;
      nxt = chain;
      for (int i = 0; i < 31; i++) if (i < chain_n - 1) nxt[i] = chain[i + 1];
      nxt[chain_n - 1] = bus.ccff_head;
      chain <= nxt;
    end
  end

  always_comb bus.ccff_tail = (tail_mode == 1) ? 1'b1 : (tail_mode == 2) ? 1'b0 : chain[0];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // cyc = cycles from the start edge until busy drops, -1 if never; gap = LOAD stall cycles
  task automatic run_seq(input int n, input int mode, input int stall, input logic [7:0] w0,
                         input logic [7:0] w1, input bit poke, input int rst_at,
                         output int cyc, output int gap);
    int idx, stall_left;
    logic [7:0] words [2];
    chain_n = n; tail_mode = mode;
    words[0] = w0; words[1] = w1;
    idx = 0; gap = 0; stall_left = stall; cyc = -1;
    @(negedge prog_clk); bus.start = 1'b1;
    @(negedge prog_clk); bus.start = 1'b0;
    for (int k = 1; k <= CYC_MAX; k++) begin
      @(negedge prog_clk);
      bus.start      = poke && (k == 5);
      bus.word_valid = 1'b0;
      if (k == rst_at) begin
        check_eq("midload_shift_en", 32'(bus.shift_en), 32'd1);
        pReset = 1'b1;
        break;
      end
      if (idx >= 1 && bus.busy && !bus.shift_en) gap++;
      if (!bus.busy) begin
        cyc = k;
        break;
      end
      if (bus.word_ready && idx < 2) begin
        if (idx == 1 && stall_left > 0) begin
          stall_left--;
        end else begin
          bus.word_valid = 1'b1;
          bus.word_data  = words[idx];
          idx++;
        end
      end
    end
    bus.start      = 1'b0;
    bus.word_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {26'd0, bus.ccff_head, bus.shift_en, bus.word_ready, bus.busy,
                             bus.config_done, 1'b0}, 32'd0);
    check_eq({tag, "_err"}, 32'(bus.err_code), 32'(ERR_NONE));
    check_eq({tag, "_len"}, 32'(bus.chain_len), 32'd0);
  endtask

  int          cyc, gap;
  logic [15:0] ref_chain;

  initial begin
    bus.start = 1'b0; bus.word_valid = 1'b0; bus.word_data = '0;
    repeat (3) @(negedge prog_clk);
    check_reset_outputs("reset");
    pReset = 1'b0;

    // nominal load, with a start pulse during FLUSH that must be ignored
    run_seq(16, 0, 0, 8'hC3, 8'hA5, 1'b1, -1, cyc, gap);
    check_eq("nom_cycles", cyc, 51);
    check_eq("nom_err", 32'(bus.err_code), 32'(ERR_NONE));
    check_eq("nom_len", 32'(bus.chain_len), 32'd16);
    check_eq("nom_done", 32'(bus.config_done), 32'd1);
    check_eq("nom_chain", 32'(chain[15:0]), 32'h0000_A5C3);
    check_eq("nom_gap", gap, 0);
    check_eq("nom_idle_outs", {30'd0, bus.shift_en, bus.word_ready}, 32'd0);
    ref_chain = chain[15:0];

    run_seq(15, 0, 0, 8'hC3, 8'hA5, 1'b0, -1, cyc, gap);
    check_eq("short_cycles", cyc, 33);
    check_eq("short_err", 32'(bus.err_code), 32'(ERR_LEN));
    check_eq("short_len", 32'(bus.chain_len), 32'd15);
    check_eq("short_done_shift", {30'd0, bus.config_done, bus.shift_en}, 32'd0);

    run_seq(16, 1, 0, 8'hC3, 8'hA5, 1'b0, -1, cyc, gap);
    check_eq("stuck1_cycles", cyc, 17);
    check_eq("stuck1_err", 32'(bus.err_code), 32'(ERR_STUCK1));
    check_eq("stuck1_done", 32'(bus.config_done), 32'd0);

    run_seq(16, 2, 0, 8'hC3, 8'hA5, 1'b0, -1, cyc, gap);
    check_eq("timeout_cycles", cyc, 49);
    check_eq("timeout_err", 32'(bus.err_code), 32'(ERR_TIMEOUT));
    check_eq("timeout_len", 32'(bus.chain_len), 32'd32);

    // restart from FAIL with a 5-cycle source stall between the two words
    run_seq(16, 0, 5, 8'hC3, 8'hA5, 1'b0, -1, cyc, gap);
    check_eq("stall_cycles", cyc, 56);
    check_eq("stall_gap", gap, 5);
    check_eq("stall_err", 32'(bus.err_code), 32'(ERR_NONE));
    check_eq("stall_chain", 32'(chain[15:0]), 32'(ref_chain));
    check_eq("stall_done", 32'(bus.config_done), 32'd1);

    run_seq(16, 0, 0, 8'h5A, 8'h3C, 1'b0, 40, cyc, gap);
    @(negedge prog_clk);
    check_reset_outputs("midload_rst");
    pReset = 1'b0;
    run_seq(16, 0, 0, 8'h5A, 8'h3C, 1'b0, -1, cyc, gap);
    check_eq("recover_cycles", cyc, 51);
    check_eq("recover_len", 32'(bus.chain_len), 32'd16);
    check_eq("recover_done", 32'(bus.config_done), 32'd1);
    check_eq("recover_chain", 32'(chain[15:0]), 32'h0000_3C5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
